serial_subtractor_eight_bit: RTL and testbench
==============================================

// Module: serial_subtractor_eight_bit
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: diff = a - b - bin, processed one bit per clock, LSB first.
//   Inverse datapath to the team's parallel ripple adder; area-cheap arithmetic for the datapath.
//   Start/busy/done handshake, so a controller or bench can chain operations back-to-back.
// PARAMETERS
//   WIDTH  8  operand and result width in bits (>= 2)
// PORTS
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; operands sampled on the cycle start=1 is accepted
//   a      in   WIDTH  minuend
//   b      in   WIDTH  subtrahend
//   bin    in   1      borrow in
//   busy   out  1      1 while a subtraction is in progress
//   done   out  1      one-cycle pulse; diff/bout valid
//   diff   out  WIDTH  result, held until the next accepted start
//   bout   out  1      borrow out, held with diff
//   ovf    out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; all internal regs cleared.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE : start=1 -> capture a,b into shift regs, borrow reg<=bin, bit counter<=0, go SHIFT.
//     SHIFT: each cycle: d=a0^b0^br; br<=(~a0&b0)|(~(a0^b0)&br); shift d into diff MSB; shift a,b right.
//            Counter increments; after WIDTH SHIFT cycles go DONE.
//     DONE : done=1 for exactly this cycle; bout<=final borrow. start=1 here is accepted (back-to-back) -> SHIFT;
//            otherwise -> IDLE.
//   busy=1 in SHIFT only. start is ignored while busy (no queueing, no error).
//   Latency: start accepted in cycle 0 -> done=1 in cycle WIDTH+1; throughput one op per WIDTH+1 cycles.
//   Result: diff = (a - b - bin) mod 2^WIDTH; bout=1 iff a < b + bin (unsigned).
//   diff/bout change only when DONE is entered; during SHIFT the visible diff is the previous result
//     (partial result shifts in a separate working reg, copied to diff on entry to DONE).
//   Operand changes after acceptance have no effect.
//   Reset asserted mid-operation: aborts immediately; no done pulse; outputs return to reset values.
//   Wrap-around: 0x00 - 0x00 - 1 = 0xFF, bout=1; bin=1 with a=b yields all-ones, bout=1.
// CONFIGURATION
//   `SERIAL_SUB_OVF_EN defined: port ovf present; ovf=(a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]) on captured
//     operands, updated with diff/bout on entry to DONE, held thereafter, reset 0.
//   Not defined: ovf port and its logic absent; all other behaviour identical.
// STRUCTURE
//   Package serial_sub_pkg: state enum (IDLE, SHIFT, DONE), counter width constant $clog2(WIDTH+1).
//   Sub-module full_subtractor (1-bit: a, b, bin -> d, bout), instantiated once in the SHIFT datapath.
//   Top holds FSM, counter, operand/working shift regs and output registers.
// TESTING (WIDTH=8; every check at the done pulse, then diff/bout re-checked one cycle later)
//   a=0x05 b=0x00 bin=0 -> done at cycle 9, diff=0x05, bout=0.
//   a=0x01 b=0x01 bin=1 -> diff=0xFF, bout=1; a=0x00 b=0xFF bin=0 -> diff=0x01, bout=1.
//   SERIAL_SUB_OVF_EN: a=0x80 b=0x01 -> diff=0x7F, ovf=1; a=0x81 b=0x01 -> diff=0x80, ovf=0.
//   start pulsed with new operands mid-SHIFT -> ignored, first result intact; start held in DONE -> next done 9 cycles later.
//   rst_n low at SHIFT cycle 4 -> no done, busy=0, diff=0 immediately; next op after release correct.
//   Random 1000 ops vs reference a-b-bin model; busy never 1 together with done.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/serial_subtractor_eight_bit_fs.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_eight_bit.sv
// Bit-serial WIDTH-bit subtractor (LSB first) with start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_eight_bit
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, nstate;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] work;
  logic [WIDTH-1:0] work_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit, br_next;
  logic             accept, last;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last      = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  // Working reg keeps only the upper WIDTH-1 partial bits; the final bit joins on the last shift.
  assign work_next = {d_bit, work};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    nstate = accept ? SHIFT : IDLE;
      SHIFT:   nstate = last   ? DONE  : SHIFT;
      DONE:    nstate = start  ? SHIFT : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      work <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= br_next;
      cnt  <= cnt + CW'(1);
      work <= work_next[WIDTH-1:1];
      if (last) begin
        diff <= work_next;
        bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
        // On the last shift the operand LSBs are the original MSBs.
        ovf  <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d_bit);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_eight_bit.sv
// Self-checking bench for serial_subtractor_eight_bit (WIDTH=8) against a transaction-level model.
module tb_serial_subtractor_eight_bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout;
  logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_chk = 0;
  int n_fail = 0;

  serial_subtractor_eight_bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op completes WIDTH+1 cycles later; results appear only then.
  int         n = 0;
  int         done_at = 0;
  bit         pending = 0;
  logic [7:0] p_diff, m_diff = '0;
  logic       p_bout, m_bout = 1'b0;
  logic       p_ovf, m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending = 0;
      m_diff  = '0;
      m_bout  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      int n_old;
      n_old = n;
      n = n + 1;
      if (pending && n == done_at) begin
        m_diff = p_diff;
        m_bout = p_bout;
        m_ovf  = p_ovf;
      end
      if (start && (!pending || n_old == done_at)) begin
        int r;
        r       = int'(a) - int'(b) - int'(bin);
        p_diff  = r[7:0];
        p_bout  = (int'(a) < int'(b) + int'(bin));
        p_ovf   = (a[7] ^ b[7]) & (a[7] ^ p_diff[7]);
        pending = 1;
        done_at = n + 8;
      end else if (pending && n > done_at) begin
        pending = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, pending && n < done_at});
    chk("done", {31'd0, done}, {31'd0, pending && n == done_at});
    chk("diff", {24'd0, diff}, {24'd0, m_diff});
    chk("bout", {31'd0, bout}, {31'd0, m_bout});
    chk("busy_and_done", {31'd0, busy & done}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
  end

  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input bit lit, input logic [7:0] ed, input logic eb, input string name);
    int k;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; bin = tbin;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; bin = $urandom_range(1);
    wait_done(k);
    chk({name, "_latency"}, k, 9);
    if (lit) begin
      chk({name, "_diff"}, {24'd0, diff}, {24'd0, ed});
      chk({name, "_bout"}, {31'd0, bout}, {31'd0, eb});
      @(negedge clk);
      chk({name, "_diff_held"}, {24'd0, diff}, {24'd0, ed});
      chk({name, "_bout_held"}, {31'd0, bout}, {31'd0, eb});
    end
  endtask

  initial begin
    int k;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    #10 rst_n = 1'b1;

    run_op(8'h05, 8'h00, 1'b0, 1, 8'h05, 1'b0, "plain");
    run_op(8'h01, 8'h01, 1'b1, 1, 8'hFF, 1'b1, "eq_bin");
    run_op(8'h00, 8'hFF, 1'b0, 1, 8'h01, 1'b1, "wrap");
    run_op(8'h00, 8'h00, 1'b1, 1, 8'hFF, 1'b1, "zero_bin");
    run_op(8'hA5, 8'h5A, 1'b1, 1, 8'h4A, 1'b0, "mixed");
`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 1, 8'h7F, 1'b0, "ovf_set");
    chk("ovf_set_flag", {31'd0, ovf}, 32'd1);
    run_op(8'h81, 8'h01, 1'b0, 1, 8'h80, 1'b0, "ovf_clr");
    chk("ovf_clr_flag", {31'd0, ovf}, 32'd0);
`endif

    // New start mid-SHIFT must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'h50; b = 8'h20; bin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 4;
    while (!done && k < 40) begin @(negedge clk); k++; end
    chk("ignore_latency", k, 9);
    chk("ignore_diff", {24'd0, diff}, 32'h30);
    chk("ignore_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    chk("ignore_no_restart", {31'd0, busy}, 32'd0);

    // Start held through DONE: back-to-back accept
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h03; bin = 1'b0;
    @(negedge clk);
    wait_done(k);
    chk("b2b_first_latency", k, 9);
    chk("b2b_first_diff", {24'd0, diff}, 32'h0D);
    a = 8'h03; b = 8'h10;
    @(negedge clk);
    wait_done(k);
    chk("b2b_second_gap", k, 9);
    chk("b2b_second_diff", {24'd0, diff}, 32'hF3);
    chk("b2b_second_bout", {31'd0, bout}, 32'd1);
    start = 1'b0;
    @(negedge clk);

    // Reset during SHIFT cycle 4
    @(negedge clk);
    start = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", {24'd0, diff}, 32'd0);
    chk("abort_bout", {31'd0, bout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", {31'd0, done}, 32'd0);
    run_op(8'h20, 8'h01, 1'b1, 1, 8'h1E, 1'b0, "after_rst");

    for (int i = 0; i < 1000; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom_range(1)), 0, 8'h00, 1'b0, "rand");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
